// File: rtl/pc_redirect_unit.sv
// Fetch PC register and branch/jump resolution for the execute stage.
// Redirects load the target and run a counted pipeline flush.
module pc_redirect_unit #(
  parameter int          n            = 32,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic         clock,
  input  logic         nReset,
  input  logic         stall,
  input  logic         branch,
  input  logic         jal,
  input  logic         jalr,
  input  logic [2:0]   funct3,
  input  logic [3:0]   flags,
  input  logic [n-1:0] pc_ex,
  input  logic [n-1:0] imm,
  input  logic [n-1:0] rs1,
  output logic [n-1:0] pc,
  output logic [n-1:0] pc_plus4,
  output logic         taken,
  output logic         flush,
  output logic         misalign,
  output logic         illegal_br
);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  localparam logic [n-1:0] PC_INC = 4;
  localparam logic [n-1:0] LSB    = 1;
  localparam logic [n-1:0] RST_PC = RESET_PC[n-1:0];
  localparam logic [n-1:0] TRAP   = TRAP_VEC[n-1:0];
  localparam logic [2:0]   FC_LAST = 3'(FLUSH_CYCLES - 1);

  state_t       state_q;
  logic [2:0]   cnt_q;
  logic [n-1:0] pc_q;
  logic         taken_q;
  logic         flush_q;
  logic         mis_q;
  logic         ill_q;

  logic         br_cond;
  logic         br_ill;
  logic         br_sel;
  logic         redirect;
  logic         tgt_mis;
  logic [n-1:0] tgt_raw;
  logic [n-1:0] tgt_d;
  logic [n-1:0] seq_d;

  always_comb begin
    br_cond = 1'b0;
    br_ill  = 1'b0;
    unique case (funct3)
      3'b000:          br_cond = flags[0];
      3'b001:          br_cond = flags[3];
      3'b100, 3'b110:  br_cond = flags[2];
      3'b101, 3'b111:  br_cond = flags[1];
      default:         br_ill  = 1'b1;
    endcase
  end

  // jalr outranks jal, which outranks a conditional branch
  assign br_sel   = branch & ~jal & ~jalr;
  assign redirect = jalr | jal | (br_sel & br_cond);
  assign tgt_raw  = jalr ? ((rs1 + imm) & ~LSB)
                         : (pc_ex + imm);
  assign tgt_mis  = tgt_raw[1];
  assign tgt_d    = tgt_mis ? TRAP : tgt_raw;
  assign seq_d    = pc_q + PC_INC;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
      pc_q    <= RST_PC;
      taken_q <= 1'b0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      taken_q <= 1'b0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      if (!stall) begin
        unique case (state_q)
          RUN: begin
            ill_q <= br_sel & br_ill;
            if (redirect) begin
              pc_q    <= tgt_d;
              taken_q <= 1'b1;
              mis_q   <= tgt_mis;
              flush_q <= 1'b1;
              cnt_q   <= FC_LAST;
              state_q <= FLUSH;
            end else begin
              pc_q    <= seq_d;
              flush_q <= 1'b0;
            end
          end
          FLUSH: begin
            pc_q <= seq_d;
            if (cnt_q != 3'd0) begin
              cnt_q <= cnt_q - 3'd1;
            end else begin
              flush_q <= 1'b0;
              state_q <= RUN;
            end
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign pc         = pc_q;
  assign pc_plus4   = seq_d;
  assign taken      = taken_q;
  assign flush      = flush_q;
  assign misalign   = mis_q;
  assign illegal_br = ill_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed plus random checks of pc_redirect_unit against a
// cycle-level reference of the PC / flush behaviour.
module tb_pc_redirect_unit;

  localparam int          N  = 32;
  localparam logic [31:0] RP = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int          FC = 2;

  logic          clock = 1'b0;
  logic          nReset;
  logic          stall, branch, jal, jalr;
  logic [2:0]    funct3;
  logic [3:0]    flags;
  logic [N-1:0]  pc_ex, imm, rs1;
  logic [N-1:0]  pc, pc_plus4;
  logic          taken, flush, misalign, illegal_br;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  logic [31:0] m_pc;
  int          m_hi;
  logic        m_tk, m_mis, m_ill;

  pc_redirect_unit #(
    .n(N), .RESET_PC(RP), .TRAP_VEC(TV), .FLUSH_CYCLES(FC)
  ) dut (
    .clock(clock), .nReset(nReset), .stall(stall),
    .branch(branch), .jal(jal), .jalr(jalr),
    .funct3(funct3), .flags(flags), .pc_ex(pc_ex),
    .imm(imm), .rs1(rs1), .pc(pc), .pc_plus4(pc_plus4),
    .taken(taken), .flush(flush), .misalign(misalign),
    .illegal_br(illegal_br)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
    chk({tag, ".taken"}, 32'(taken), 32'(m_tk));
    chk({tag, ".flush"}, 32'(flush), 32'(m_hi > 0));
    chk({tag, ".mis"}, 32'(misalign), 32'(m_mis));
    chk({tag, ".ill"}, 32'(illegal_br), 32'(m_ill));
  endtask

  task automatic m_reset();
    m_pc = RP; m_hi = 0;
    m_tk = 0; m_mis = 0; m_ill = 0;
  endtask

  // advance the reference by one clock using current inputs
  task automatic m_step();
    logic        go;
    logic [31:0] t;
    m_tk = 0; m_mis = 0; m_ill = 0;
    if (stall) return;
    if (m_hi > 0) begin
      m_pc = m_pc + 32'd4;
      m_hi = m_hi - 1;
      return;
    end
    go = 0; t = '0;
    if (jalr) begin
      go = 1; t = (rs1 + imm) & 32'hFFFF_FFFE;
    end else if (jal) begin
      go = 1; t = pc_ex + imm;
    end else if (branch) begin
      t = pc_ex + imm;
      case (funct3)
        3'd0: go = flags[0];
        3'd1: go = flags[3];
        3'd4, 3'd6: go = flags[2];
        3'd5, 3'd7: go = flags[1];
        default: m_ill = 1;
      endcase
    end
    if (go) begin
      if (t[1]) begin t = TV; m_mis = 1; end
      m_pc = t; m_tk = 1; m_hi = FC;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic idle();
    stall = 0; branch = 0; jal = 0; jalr = 0;
    funct3 = 0; flags = 0; pc_ex = 0; imm = 0; rs1 = 0;
  endtask

  task automatic tick(input string tag);
    m_step();
    @(posedge clock);
    #1;
    chk_all(tag);
  endtask

  initial begin
    idle();
    nReset = 0;
    m_reset();
    #12;
    chk_all("rst");
    @(negedge clock);
    nReset = 1;
    @(posedge clock); #1;
    m_reset();
    m_pc = RP;
    // the edge above moved pc once
    m_pc = RP + 32'd4;
    chk_all("seq0");
    tick("seq1");
    tick("seq2");

    // taken beq
    pc_ex = 32'h40; imm = 32'h20; branch = 1;
    funct3 = 3'b000; flags = 4'b0011;
    tick("beq");
    chk("beq.pcval", pc, 32'h60);
    idle();
    tick("fl1");
    tick("fl2");
    chk("fl2.run", 32'(flush), 0);
    tick("run");

    // jalr wins over branch, bit0 cleared
    jalr = 1; branch = 1; funct3 = 0; flags = 4'hF;
    rs1 = 32'h1001; imm = 32'h4;
    tick("jalr");
    chk("jalr.pcval", pc, 32'h1004);
    idle();
    tick("jf1"); tick("jf2");
    jalr = 1; branch = 1; rs1 = 32'h1002; imm = 32'h4;
    tick("jmis");
    chk("jmis.pcval", pc, TV);
    idle();
    tick("mf1"); tick("mf2");

    // illegal funct3 then redirect during flush
    branch = 1; funct3 = 3'b010; flags = 4'hF;
    pc_ex = 32'h200; imm = 32'h10;
    tick("ill");
    funct3 = 3'b000;
    tick("beq2");
    jal = 1; pc_ex = 32'h800; imm = 32'h8;
    tick("ign1");
    tick("ign2");
    idle();
    tick("post");

    // stall held in FLUSH
    jal = 1; pc_ex = 32'h300; imm = 32'h0;
    tick("jal");
    idle();
    stall = 1;
    tick("st1"); tick("st2"); tick("st3");
    stall = 0;
    tick("rel1");
    tick("rel2");

    // async reset mid-flush
    jal = 1; pc_ex = 32'h500; imm = 32'h4;
    tick("jal2");
    idle();
    #2;
    nReset = 0;
    #1;
    m_reset();
    chk_all("arst");
    @(negedge clock);
    nReset = 1;
    @(posedge clock); #1;
    m_pc = RP + 32'd4;
    chk_all("arst.run");

    // wrap-around
    jalr = 1; rs1 = 32'hFFFF_FFF4; imm = 0;
    tick("wj");
    idle();
    tick("w1"); tick("w2");
    chk("w2.pcval", pc, 32'hFFFF_FFFC);
    chk("w2.pc4", pc_plus4, 32'h0);
    tick("w3");
    chk("w3.pcval", pc, 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      stall  = ($urandom_range(0, 4) == 0);
      branch = ($urandom_range(0, 2) == 0);
      jal    = ($urandom_range(0, 7) == 0);
      jalr   = ($urandom_range(0, 7) == 0);
      funct3 = 3'($urandom);
      flags  = 4'($urandom);
      pc_ex  = $urandom & 32'hFFFF_FFFC;
      imm    = $urandom_range(0, 3) == 0 ? $urandom
                                         : ($urandom & 32'hFFC);
      rs1    = $urandom;
      tick("rnd");
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1);
  end

endmodule
